// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin scheduler that shares one UART transmitter among
//               NREQ byte producers. One byte is accepted per transfer through
//               a valid/ready handshake and launched with a one-cycle tx_en.
//               The arbiter then waits for tx_done, pulses the owner's
//               req_done, and rotates priority.
//               Optional watchdog abort of a stalled transfer is enabled by
//               defining the macro UART_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int GW             = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_done,
  output logic [GW-1:0]     grant_id,
  output logic              busy,
  output logic              tx_en,
  output logic [7:0]        tx_din,
  input  logic              tx_done,
  output logic              err_timeout
);

  // Elaboration-time guard on the supported configuration range.
  generate
    if (NREQ < 2 || NREQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("uart_tx_arbiter: NREQ must be 2..16 and TIMEOUT_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_last_grant;
  logic [GW-1:0]   r_grant_id;
  logic            r_busy;
  logic            r_tx_en;
  logic [7:0]      r_tx_din;
  logic [NREQ-1:0] r_req_done;

  logic            w_found;
  logic [GW-1:0]   w_winner;
  logic [GW:0]     w_pos;
  logic [7:0]      w_byte;
  logic [NREQ-1:0] w_ready;

  // Round-robin pick: scan downward so the closest requester after last_grant wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_pos    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_pos = {1'b0, r_last_grant} + (GW+1)'(k);
      if (w_pos >= (GW+1)'(NREQ)) begin
        w_pos = w_pos - (GW+1)'(NREQ);
      end
      if (req_valid[w_pos[GW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_pos[GW-1:0];
      end
    end
  end

  // Select the winner's byte from the flattened data bus.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (GW'(i) == w_winner) begin
        w_byte = req_data[8*i +: 8];
      end
    end
  end

  // Ready is offered only while idle, and only to the winning requester.
  always_comb begin
    w_ready = '0;
    if (r_state == S_IDLE && w_found) begin
      w_ready[w_winner] = 1'b1;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wd_cnt;
  logic          r_err_timeout;
  logic          w_expired;

  // Expiry fires on the TIMEOUT_CYCLES-th cycle spent in WAIT.
  always_comb begin
    w_expired = (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  end
`endif

  // Transfer sequencer: accept, launch, wait for completion (or abort).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GW'(NREQ - 1);
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_tx_en       <= 1'b0;
      r_tx_din      <= '0;
      r_req_done    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_wd_cnt      <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_tx_en       <= 1'b0;
      r_req_done    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_err_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_tx_din   <= w_byte;
            r_grant_id <= w_winner;
            r_busy     <= 1'b1;
            r_tx_en    <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          // tx_done is deliberately not looked at in the launch cycle.
          r_state <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (tx_done) begin
            r_req_done[r_grant_id] <= 1'b1;
            r_last_grant           <= r_grant_id;
            r_busy                 <= 1'b0;
            r_state                <= S_IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (w_expired) begin
            r_err_timeout <= 1'b1;
            r_last_grant  <= r_grant_id;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_ready;
  assign req_done  = r_req_done;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign tx_en     = r_tx_en;
  assign tx_din    = r_tx_din;
`ifdef UART_ARB_TIMEOUT_EN
  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

`default_nettype wire
